// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: store-and-forward echo buffer between uart_rx and uart_tx, FIFO or LIFO order
module uart_echo_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int LIFO         = 0,
  parameter int THRESHOLD    = DEPTH,
  parameter int TIMEOUT_CLKS = 0
) (
  input  logic                       hwclk,
  input  logic                       rst_n,
  input  logic                       rx_dv,
  input  logic [DATA_WIDTH-1:0]      rx_byte,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic                       tx_dv,
  output logic [DATA_WIDTH-1:0]      tx_byte,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       draining,
  output logic                       overflow,
  output logic [15:0]                drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] THR_C = CW'(THRESHOLD);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         top_addr, rd_addr, wr_addr;
  logic [CW-1:0]         count_q, count_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  busy_q, busy_d;
  logic                  tx_dv_q;
  logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
  logic                  full_q, empty_q;
  logic                  overflow_q, overflow_d;
  logic [15:0]           drop_q, drop_d;
  logic                  launch, push, timeout_hit;

  // Datapath: a launch pops before the push, so a push at full is taken when a pop frees the slot;
  // in LIFO the stack pointer is the fill count itself.
  always_comb begin
    launch     = (state_q == S_DRAIN) && !busy_q && !tx_active && (count_q != '0);
    push       = rx_dv && ((count_q != DEPTH_C) || launch);
    top_addr   = AW'(count_q - CW'(1));
    rd_addr    = (LIFO != 0) ? top_addr : rd_ptr_q;
    wr_addr    = (LIFO != 0) ? (launch ? top_addr : AW'(count_q)) : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q + AW'(launch);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    count_d    = count_q + CW'(push) - CW'(launch);
    busy_d     = launch || (busy_q && !tx_done);
    tx_byte_d  = launch ? mem_q[rd_addr] : tx_byte_q;
    overflow_d = rx_dv && !push;
    drop_d     = (overflow_d && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  // Next state: fill until threshold or idle timeout, drain until the buffer and uart_tx are both idle.
  always_comb begin
    timeout_hit = (TIMEOUT_CLKS != 0) && (count_q != '0) && (timer_q == TLAST);
    state_d     = (state_q == S_FILL) ? (((count_d >= THR_C) || timeout_hit) ? S_DRAIN : S_FILL)
                                      : ((!busy_q && (count_q == '0)) ? S_FILL : S_DRAIN);
    timer_d     = ((state_q == S_DRAIN) || rx_dv || (count_q == '0) || (TIMEOUT_CLKS == 0)) ? '0
                                                                                           : timer_q + TW'(1);
  end

  // State, pointers, counters and registered status; reset abandons the buffer contents.
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      tx_dv_q    <= launch;
      tx_byte_q  <= tx_byte_d;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage array, never cleared; writes are blocked while in reset.
  always_ff @(posedge hwclk) begin
    if (rst_n && push) mem_q[wr_addr] <= rx_byte;
  end

  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign draining   = (state_q == S_DRAIN);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
endmodule
